led_pattern_gen: RTL and testbench

//  Parametrised LED driver: a runtime-programmable prescaler advances a WIDTH-bit output

---
 rtl/led_pattern_gen.sv | 112 +++++++++++
 tb/tb_led_pattern_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - prescaled LED pattern generator (up, down, bouncing scan, blink)
module led_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int PS_W  = 27
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [PS_W-1:0]  DIV,
  input  logic [1:0]       MODE,
  output logic [WIDTH-1:0] OUT,
  output logic             TICK
);

  localparam logic [1:0] M_UP    = 2'b00;
  localparam logic [1:0] M_DOWN  = 2'b01;
  localparam logic [1:0] M_SCAN  = 2'b10;
  localparam logic [1:0] M_BLINK = 2'b11;

  logic [PS_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             tick_q, tick_d;
  logic [1:0]       mode_q, mode_d;
  logic             dir_left_q, dir_left_d;

  logic [WIDTH-1:0] out_init;
  logic [WIDTH-1:0] out_next;
  logic             dir_next;

  always_comb begin
    case (MODE)
      M_DOWN:  out_init = '1;
      M_SCAN:  out_init = WIDTH'(1);
      default: out_init = '0;
    endcase
  end

  // Scan bounces off each end without repeating the endpoint; a single LED never moves.
  always_comb begin
    out_next = out_q;
    dir_next = dir_left_q;
    case (mode_q)
      M_UP:    out_next = out_q + WIDTH'(1);
      M_DOWN:  out_next = out_q - WIDTH'(1);
      M_BLINK: out_next = ~out_q;
      M_SCAN: begin
        if (WIDTH > 1) begin
          if (dir_left_q) begin
            if (out_q[WIDTH-1]) begin
              out_next = out_q >> 1;
              dir_next = 1'b0;
            end else begin
              out_next = out_q << 1;
            end
          end else begin
            if (out_q[0]) begin
              out_next = out_q << 1;
              dir_next = 1'b1;
            end else begin
              out_next = out_q >> 1;
            end
          end
        end
      end
      default: out_next = out_q;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    out_d      = out_q;
    tick_d     = 1'b0;
    mode_d     = mode_q;
    dir_left_d = dir_left_q;
    if (MODE != mode_q) begin
      mode_d     = MODE;
      out_d      = out_init;
      cnt_d      = '0;
      dir_left_d = 1'b1;
    end else if (EN) begin
      // >= lets a lowered DIV terminate an over-long period on the next edge
      if (cnt_q >= DIV) begin
        cnt_d      = '0;
        tick_d     = 1'b1;
        out_d      = out_next;
        dir_left_d = dir_next;
      end else begin
        cnt_d = cnt_q + PS_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q      <= '0;
      out_q      <= out_init;
      tick_q     <= 1'b0;
      mode_q     <= MODE;
      dir_left_q <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      tick_q     <= tick_d;
      mode_q     <= mode_d;
      dir_left_q <= dir_left_d;
    end
  end

  assign OUT  = out_q;
  assign TICK = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - self-checking bench for led_pattern_gen (WIDTH 8 and WIDTH 4)
module tb_led_pattern_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [26:0] div = '0;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  out8;
  logic [3:0]  out4;
  logic        tick8, tick4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  led_pattern_gen #(.WIDTH(8), .PS_W(27)) dut8 (
    .CLK(clk), .RST(rst), .EN(en), .DIV(div), .MODE(mode), .OUT(out8), .TICK(tick8)
  );

  led_pattern_gen #(.WIDTH(4), .PS_W(27)) dut4 (
    .CLK(clk), .RST(rst), .EN(en), .DIV(div), .MODE(mode), .OUT(out4), .TICK(tick4)
  );

  // Reference model: index 0 is the 8-LED instance, index 1 the 4-LED instance.
  int m_cnt[2];
  int m_val[2];
  int m_pos[2];
  int m_mode[2];
  bit m_dirl[2];
  bit m_tick[2];

  function automatic int init_val(int md, int w);
    case (md)
      1:       return (1 << w) - 1;
      2:       return 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input int i, input int w);
    int full;
    full = 1 << w;
    if (rst || int'(mode) != m_mode[i]) begin
      m_cnt[i]  = 0;
      m_tick[i] = 0;
      m_mode[i] = int'(mode);
      m_pos[i]  = 0;
      m_dirl[i] = 1;
      m_val[i]  = init_val(int'(mode), w);
    end else if (en) begin
      if (m_cnt[i] >= int'(div)) begin
        m_cnt[i]  = 0;
        m_tick[i] = 1;
        case (m_mode[i])
          0: m_val[i] = (m_val[i] + 1) % full;
          1: m_val[i] = (m_val[i] + full - 1) % full;
          3: m_val[i] = (full - 1) - m_val[i];
          default: begin
            if (w > 1) begin
              if (m_dirl[i]) begin
                if (m_pos[i] == w - 1) begin m_dirl[i] = 0; m_pos[i]--; end
                else m_pos[i]++;
              end else begin
                if (m_pos[i] == 0) begin m_dirl[i] = 1; m_pos[i]++; end
                else m_pos[i]--;
              end
            end
            m_val[i] = 1 << m_pos[i];
          end
        endcase
      end else begin
        m_cnt[i]++;
        m_tick[i] = 0;
      end
    end else begin
      m_tick[i] = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0, 8);
    model_step(1, 4);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [26:0] d, input logic [1:0] m);
    rst  = r;
    en   = e;
    div  = d;
    mode = m;
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic [26:0] div;
    logic [1:0]  mode;
    logic [7:0]  exp_out;
    logic        exp_tick;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic e, logic [26:0] d, logic [1:0] m,
                              logic [7:0] o, logic t, string n);
    vec_t v;
    v.rst = r; v.en = e; v.div = d; v.mode = m;
    v.exp_out = o; v.exp_tick = t; v.name = n;
    return v;
  endfunction

  logic [7:0] scan8_seq [0:15];
  logic [3:0] scan4_seq [0:7];

  initial begin
    // Reset values, then up-count timing, then wrap in both directions.
    vecs.push_back(mk(1, 0, 0, 2'b00, 8'h00, 0, "reset_up"));
    vecs.push_back(mk(1, 0, 0, 2'b00, 8'h00, 0, "reset_up"));
    vecs.push_back(mk(1, 0, 0, 2'b10, 8'h01, 0, "reset_scan"));
    vecs.push_back(mk(1, 0, 0, 2'b10, 8'h01, 0, "reset_scan"));
    vecs.push_back(mk(1, 1, 3, 2'b00, 8'h00, 0, "up_div3_reset"));
    for (int k = 1; k <= 12; k++)
      vecs.push_back(mk(0, 1, 3, 2'b00, 8'(k / 4), (k % 4) == 0, "up_div3"));
    vecs.push_back(mk(1, 1, 0, 2'b00, 8'h00, 0, "wrap_up_reset"));
    for (int k = 1; k <= 258; k++)
      vecs.push_back(mk(0, 1, 0, 2'b00, 8'(k % 256), 1, "wrap_up"));
    vecs.push_back(mk(1, 1, 0, 2'b01, 8'hFF, 0, "wrap_down_reset"));
    for (int k = 1; k <= 258; k++)
      vecs.push_back(mk(0, 1, 0, 2'b01, 8'((255 - k + 512) % 256), 1, "wrap_down"));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].div, vecs[i].mode);
      step();
      check({vecs[i].name, "_out"}, 32'(out8), 32'(vecs[i].exp_out));
      check({vecs[i].name, "_tick"}, 32'(tick8), 32'(vecs[i].exp_tick));
    end

    // Scan bounce on both widths with DIV=0.
    scan4_seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
    scan8_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    drive(1, 1, 0, 2'b10);
    step();
    check("scan4_init", 32'(out4), 32'(scan4_seq[0]));
    check("scan8_init", 32'(out8), 32'(scan8_seq[0]));
    rst = 0;
    for (int k = 1; k < 16; k++) begin
      step();
      if (k < 8) check("scan4_step", 32'(out4), 32'(scan4_seq[k]));
      check("scan8_step", 32'(out8), 32'(scan8_seq[k]));
      check("scan_tick", 32'(tick4), 32'd1);
    end

    // Freeze with EN=0 at cnt=5, resume, then shrink DIV below the running count.
    drive(1, 1, 9, 2'b00);
    step();
    rst = 0;
    for (int k = 0; k < 5; k++) step();
    en = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("freeze_out", 32'(out8), 32'h00);
      check("freeze_tick", 32'(tick8), 32'd0);
    end
    en = 1;
    for (int k = 1; k <= 5; k++) begin
      step();
      check("resume_tick", 32'(tick8), 32'(k == 5));
    end
    check("resume_out", 32'(out8), 32'h01);
    for (int k = 0; k < 7; k++) step();
    check("pre_div_change_tick", 32'(tick8), 32'd0);
    div = 2;
    step();
    check("div_shrink_tick", 32'(tick8), 32'd1);
    check("div_shrink_out", 32'(out8), 32'h02);
    for (int k = 1; k <= 6; k++) begin
      step();
      check("div2_tick", 32'(tick8), 32'((k % 3) == 0));
      check("div2_out", 32'(out8), 32'(2 + k / 3));
    end

    // Mode change mid-count: up at 0x05 with cnt=2, switch to blink.
    drive(1, 1, 4, 2'b00);
    step();
    rst = 0;
    for (int k = 0; k < 27; k++) step();
    check("pre_mode_out", 32'(out8), 32'h05);
    mode = 2'b11;
    step();
    check("mode_chg_out", 32'(out8), 32'h00);
    check("mode_chg_tick", 32'(tick8), 32'd0);
    for (int k = 1; k <= 15; k++) begin
      step();
      check("blink_tick", 32'(tick8), 32'((k % 5) == 0));
      check("blink_out", 32'(out8), ((k / 5) % 2) ? 32'hFF : 32'h00);
    end

    // Randomised run against the reference model.
    drive(1, 1, 2, 2'b00);
    step();
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 59) == 0);
      en  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) div = 27'($urandom_range(0, 4));
      step();
      check("rand_out8", 32'(out8), 32'(m_val[0]));
      check("rand_tick8", 32'(tick8), 32'(m_tick[0]));
      check("rand_out4", 32'(out4), 32'(m_val[1]));
      check("rand_tick4", 32'(tick4), 32'(m_tick[1]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
